wb_memtest_master: RTL and testbench

- Wishbone bus master that generates traffic into the cached SDRAM subsystem's `if_wb` slave port, at the initiator end of that bus.
- On a start pulse it writes a pseudo-random pattern over a word range, then reads the range back and compares.
- Reports pass/fail, error count, first failing address and bus timeout. Used for board bring-up and as a traffic source in SDRAM/cache regression.

---
 rtl/wb_memtest_master_if.sv | 21 ++
 rtl/wb_memtest_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_memtest_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_memtest_master_if.sv
// Wishbone classic bus between the memtest master and the cached SDRAM slave port.
interface if_wb;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] wdat;
   logic [31:0] rdat;
   logic        ack;

   modport master (
      output cyc, stb, we, sel, adr, wdat,
      input  rdat, ack
   );

   modport slave (
      input  cyc, stb, we, sel, adr, wdat,
      output rdat, ack
   );
endinterface

// File: rtl/wb_memtest_master.sv
// Wishbone memory test master: writes an LFSR pattern over a word range, reads it back and compares.
// Define WB_MEMTEST_ADDR_XOR_EN to mix the word address into the pattern, which exposes address aliasing.
module wb_memtest_master #(
   parameter logic [31:0] ADDR_INC  = 32'd4,
   parameter int unsigned TIMEOUT   = 1023,
   parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
   input  logic        clk_i,
   input  logic        rst_i,
   if_wb.master        bus,
   input  logic        start_i,
   input  logic [31:0] base_i,
   input  logic [15:0] count_i,
   input  logic [31:0] seed_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_count_o,
   output logic [31:0] first_err_adr_o,
   output logic        timeout_o
);

`ifdef WB_MEMTEST_ADDR_XOR_EN
   localparam bit ADDR_XOR = 1'b1;
`else
   localparam bit ADDR_XOR = 1'b0;
`endif

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR, GAP, RD, FIN} state_t;

   state_t      state;
   logic [31:0] base_q;
   logic [31:0] seed_q;
   logic [15:0] count_q;
   logic [15:0] idx;
   logic [31:0] lfsr;
   logic [9:0]  tmo_cnt;

   logic [31:0] seed_eff;
   logic [31:0] lfsr_nxt;
   logic [31:0] adr_nxt;
   logic        last;
   logic        mismatch;
   logic        tmo_hit;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'd0);
   endfunction

   function automatic logic [31:0] pattern(input logic [31:0] l, input logic [31:0] a);
      return l ^ (ADDR_XOR ? a : 32'd0);
   endfunction

   always_comb begin
      seed_eff = (seed_i == 32'd0) ? 32'd1 : seed_i;
      lfsr_nxt = lfsr_step(lfsr);
      adr_nxt  = bus.adr + ADDR_INC;
      last     = (idx == count_q - 16'd1);
      mismatch = (bus.rdat != pattern(lfsr, bus.adr));
      tmo_hit  = (tmo_cnt == TMO_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state           <= IDLE;
         base_q          <= '0;
         seed_q          <= '0;
         count_q         <= '0;
         idx             <= '0;
         lfsr            <= '0;
         tmo_cnt         <= '0;
         bus.cyc         <= 1'b0;
         bus.stb         <= 1'b0;
         bus.we          <= 1'b0;
         bus.sel         <= '0;
         bus.adr         <= '0;
         bus.wdat        <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         err_count_o     <= '0;
         first_err_adr_o <= '0;
         timeout_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  base_q          <= base_i;
                  count_q         <= count_i;
                  seed_q          <= seed_eff;
                  idx             <= '0;
                  tmo_cnt         <= '0;
                  busy_o          <= 1'b1;
                  pass_o          <= 1'b0;
                  err_count_o     <= '0;
                  first_err_adr_o <= '0;
                  timeout_o       <= 1'b0;
                  if (count_i == 16'd0) begin
                     state <= FIN;
                  end else begin
                     // Bus is raised on the same edge so the first strobe follows start by one cycle.
                     state    <= WR;
                     lfsr     <= seed_eff;
                     bus.adr  <= base_i;
                     bus.wdat <= pattern(seed_eff, base_i);
                     bus.cyc  <= 1'b1;
                     bus.stb  <= 1'b1;
                     bus.we   <= 1'b1;
                     bus.sel  <= 4'hF;
                  end
               end
            end

            WR: begin
               if (bus.ack) begin
                  tmo_cnt  <= '0;
                  idx      <= idx + 16'd1;
                  bus.adr  <= adr_nxt;
                  lfsr     <= lfsr_nxt;
                  bus.wdat <= pattern(lfsr_nxt, adr_nxt);
                  if (last) begin
                     state   <= GAP;
                     bus.cyc <= 1'b0;
                     bus.stb <= 1'b0;
                     bus.we  <= 1'b0;
                     bus.sel <= '0;
                  end
               end else if (tmo_hit) begin
                  state     <= FIN;
                  timeout_o <= 1'b1;
                  bus.cyc   <= 1'b0;
                  bus.stb   <= 1'b0;
                  bus.we    <= 1'b0;
                  bus.sel   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 10'd1;
               end
            end

            GAP: begin
               state   <= RD;
               idx     <= '0;
               tmo_cnt <= '0;
               lfsr    <= seed_q;
               bus.adr <= base_q;
               bus.cyc <= 1'b1;
               bus.stb <= 1'b1;
               bus.we  <= 1'b0;
               bus.sel <= 4'hF;
            end

            RD: begin
               if (bus.ack) begin
                  tmo_cnt <= '0;
                  if (mismatch) begin
                     if (err_count_o != 16'hFFFF)
                        err_count_o <= err_count_o + 16'd1;
                     if (err_count_o == 16'd0)
                        first_err_adr_o <= bus.adr;
                  end
                  idx     <= idx + 16'd1;
                  bus.adr <= adr_nxt;
                  lfsr    <= lfsr_nxt;
                  if (last) begin
                     state   <= FIN;
                     bus.cyc <= 1'b0;
                     bus.stb <= 1'b0;
                     bus.sel <= '0;
                  end
               end else if (tmo_hit) begin
                  // The outstanding read is abandoned without being compared.
                  state     <= FIN;
                  timeout_o <= 1'b1;
                  bus.cyc   <= 1'b0;
                  bus.stb   <= 1'b0;
                  bus.sel   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 10'd1;
               end
            end

            FIN: begin
               state  <= IDLE;
               done_o <= 1'b1;
               busy_o <= 1'b0;
               pass_o <= (err_count_o == 16'd0) && !timeout_o;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_memtest_master.sv
// Scoreboard bench for wb_memtest_master: expected bus transfers and results are queued at start,
// a negedge monitor pops and compares them as the DUT acks transfers and pulses done.
module tb_wb_memtest_master;

`ifdef WB_MEMTEST_ADDR_XOR_EN
   localparam bit XOR_EN = 1'b1;
`else
   localparam bit XOR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] base_i;
   logic [15:0] count_i;
   logic [31:0] seed_i;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic [15:0] err_count_o;
   logic [31:0] first_err_adr_o;
   logic        timeout_o;

   if_wb bus ();

   wb_memtest_master #(.TIMEOUT(16)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .bus             (bus),
      .start_i         (start_i),
      .base_i          (base_i),
      .count_i         (count_i),
      .seed_i          (seed_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .pass_o          (pass_o),
      .err_count_o     (err_count_o),
      .first_err_adr_o (first_err_adr_o),
      .timeout_o       (timeout_o)
   );

   always #5 clk = ~clk;

   // Hand-computed LFSR sequence from seed 1.
   logic [31:0] pat [0:7] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                              32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003};

   // Zero-wait slave with optional hang, read corruption and address aliasing.
   logic        hang_en, corrupt_en, alias_en;
   logic [31:0] hang_adr, corrupt_adr;
   logic [31:0] mem [0:63];
   logic [5:0]  midx;

   assign midx     = alias_en ? (bus.adr[7:2] & 6'h3E) : bus.adr[7:2];
   assign bus.ack  = bus.cyc & bus.stb & ~(hang_en & bus.we & (bus.adr == hang_adr));
   assign bus.rdat = mem[midx] ^ {31'd0, corrupt_en && (bus.adr == corrupt_adr)};

   always @(posedge clk)
      if (bus.cyc && bus.stb && bus.ack && bus.we) mem[midx] <= bus.wdat;

   typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} xfer_t;
   typedef struct packed {logic pass; logic [15:0] err; logic [31:0] first; logic tmo;} res_t;
   xfer_t exp_q [$];
   res_t  res_q [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int i, input logic [31:0] a);
      return pat[i] ^ (XOR_EN ? a : 32'd0);
   endfunction

   task automatic push_run(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, base + 32'(4*i), exp_data(i, base + 32'(4*i))});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, base + 32'(4*i), 32'd0});
   endtask

   task automatic push_res(input logic p, input logic [15:0] e, input logic [31:0] f, input logic t);
      res_q.push_back({p, e, f, t});
   endtask

   task automatic start(input logic [31:0] b, input logic [15:0] c, input logic [31:0] s);
      @(posedge clk); #1;
      base_i = b; count_i = c; seed_i = s; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done_o) chk({name, "_done_wait"}, 32'd0, 32'd1);
   endtask

   task automatic post(input string name);
      @(negedge clk);
      chk({name, "_done_pulse"}, {31'd0, done_o}, 32'd0);
      chk({name, "_busy_end"}, {31'd0, busy_o}, 32'd0);
      chk({name, "_xfers_left"}, exp_q.size(), 32'd0);
      chk({name, "_results_left"}, res_q.size(), 32'd0);
   endtask

   // Monitor: every acked transfer and every done pulse is matched against the queues.
   xfer_t x;
   res_t  r;
   always @(negedge clk) begin
      if (bus.stb && !bus.cyc) chk("stb_without_cyc", 32'd1, 32'd0);
      if (bus.cyc && bus.stb && bus.ack) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", bus.adr, 32'hFFFF_FFFF);
         end else begin
            x = exp_q.pop_front();
            chk("xfer_we", {31'd0, bus.we}, {31'd0, x.we});
            chk("xfer_adr", bus.adr, x.adr);
            chk("xfer_sel", {28'd0, bus.sel}, 32'hF);
            if (x.we) chk("xfer_wdat", bus.wdat, x.dat);
         end
      end
      if (done_o) begin
         if (res_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            r = res_q.pop_front();
            chk("res_pass", {31'd0, pass_o}, {31'd0, r.pass});
            chk("res_err_count", {16'd0, err_count_o}, {16'd0, r.err});
            chk("res_first_err_adr", first_err_adr_o, r.first);
            chk("res_timeout", {31'd0, timeout_o}, {31'd0, r.tmo});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_i = 1'b0; start_i = 1'b0; base_i = '0; count_i = '0; seed_i = '0;
      hang_en = 1'b0; corrupt_en = 1'b0; alias_en = 1'b0; hang_adr = '0; corrupt_adr = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cyc", {31'd0, bus.cyc}, 32'd0);
      chk("rst_stb", {31'd0, bus.stb}, 32'd0);
      chk("rst_we", {31'd0, bus.we}, 32'd0);
      chk("rst_sel", {28'd0, bus.sel}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_pass", {31'd0, pass_o}, 32'd0);
      chk("rst_err", {16'd0, err_count_o}, 32'd0);
      chk("rst_first", first_err_adr_o, 32'd0);
      chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b1;

      // Clean run: 4 writes, one idle cycle, 4 reads.
      push_run(32'h1000, 4);
      push_res(1'b1, 16'd0, 32'd0, 1'b0);
      start(32'h1000, 16'd4, 32'd1);
      @(negedge clk);
      chk("first_stb_latency", {31'd0, bus.stb}, 32'd1);
      chk("busy_after_start", {31'd0, busy_o}, 32'd1);
      n = 0;
      while (!(bus.cyc && bus.we && bus.adr == 32'h100C) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("gap_cyc_low", {31'd0, bus.cyc}, 32'd0);
      @(negedge clk);
      chk("gap_then_read", {bus.cyc, bus.we, bus.adr[29:0]}, {2'b10, 30'h1000});
      wait_done("clean");
      post("clean");

      // Corrupted read at 0x1008, plus a start pulse while busy that must be ignored.
      corrupt_en = 1'b1; corrupt_adr = 32'h1008;
      push_run(32'h1000, 4);
      push_res(1'b0, 16'd1, 32'h1008, 1'b0);
      start(32'h1000, 16'd4, 32'd1);
      @(posedge clk); #1;
      base_i = 32'h2000; count_i = 16'd1; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_done("corrupt");
      post("corrupt");
      corrupt_en = 1'b0;

      // Zero-length test: no bus activity, done two cycles after start.
      push_res(1'b1, 16'd0, 32'd0, 1'b0);
      start(32'h3000, 16'd0, 32'd5);
      @(negedge clk);
      chk("cnt0_done_early", {31'd0, done_o}, 32'd0);
      chk("cnt0_cyc_a", {31'd0, bus.cyc}, 32'd0);
      @(negedge clk);
      chk("cnt0_done", {31'd0, done_o}, 32'd1);
      chk("cnt0_cyc_b", {31'd0, bus.cyc}, 32'd0);
      post("cnt0");

      // Second write never acked: strobe held for TIMEOUT cycles, then abort.
      hang_en = 1'b1; hang_adr = 32'h1004;
      exp_q.push_back({1'b1, 32'h1000, exp_data(0, 32'h1000)});
      push_res(1'b0, 16'd0, 32'd0, 1'b1);
      start(32'h1000, 16'd8, 32'd1);
      n = 0;
      while (!(bus.stb && bus.adr == 32'h1004) && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (bus.stb && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_stb_cycles", n, 32'd16);
      chk("tmo_cyc_drop", {31'd0, bus.cyc}, 32'd0);
      chk("tmo_flag", {31'd0, timeout_o}, 32'd1);
      wait_done("tmo");
      post("tmo");
      hang_en = 1'b0;

      // Reset during the third read of eight.
      push_run(32'h1000, 8);
      push_res(1'b1, 16'd0, 32'd0, 1'b0);
      start(32'h1000, 16'd8, 32'd1);
      n = 0;
      while (!(bus.cyc && bus.stb && !bus.we && bus.adr == 32'h1008) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reached", {31'd0, bus.adr == 32'h1008}, 32'd1);
      rst_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("midrst_cyc", {31'd0, bus.cyc}, 32'd0);
      chk("midrst_stb", {31'd0, bus.stb}, 32'd0);
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      chk("midrst_err", {16'd0, err_count_o}, 32'd0);
      chk("midrst_first", first_err_adr_o, 32'd0);
      chk("midrst_timeout", {31'd0, timeout_o}, 32'd0);
      chk("midrst_pass", {31'd0, pass_o}, 32'd0);
      exp_q.delete();
      res_q.delete();

      // Seed 0 must behave as seed 1.
      push_run(32'h1000, 4);
      push_res(1'b1, 16'd0, 32'd0, 1'b0);
      start(32'h1000, 16'd4, 32'd0);
      wait_done("seed0");
      post("seed0");

`ifdef WB_MEMTEST_ADDR_XOR_EN
      // Address-mixed pattern against a slave that aliases 0x4 onto 0x0.
      alias_en = 1'b1;
      exp_q.push_back({1'b1, 32'h0, 32'h0000_0001});
      exp_q.push_back({1'b1, 32'h4, 32'h8020_0007});
      exp_q.push_back({1'b0, 32'h0, 32'h0});
      exp_q.push_back({1'b0, 32'h4, 32'h0});
      push_res(1'b0, 16'd1, 32'h0, 1'b0);
      start(32'h0, 16'd2, 32'd1);
      wait_done("alias");
      post("alias");
      alias_en = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
